// File: rtl/ext_aw_splitter.sv
// Splits a byte-addressed write command into AXI4 INCR AW bursts that never
// cross a 4 KB page and never exceed 256 beats; issues them back-to-back.
module ext_aw_splitter #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 6,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  cmd_valid_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [ID_WIDTH-1:0]   cmd_id_i,
  input  logic [USER_WIDTH-1:0] cmd_user_i,
  output logic                  cmd_ready_o,

  output logic                  aw_valid_o,
  output logic [ADDR_WIDTH-1:0] aw_addr_o,
  output logic [2:0]            aw_prot_o,
  output logic [3:0]            aw_region_o,
  output logic [7:0]            aw_len_o,
  output logic [2:0]            aw_size_o,
  output logic [1:0]            aw_burst_o,
  output logic                  aw_lock_o,
  output logic [3:0]            aw_cache_o,
  output logic [3:0]            aw_qos_o,
  output logic [ID_WIDTH-1:0]   aw_id_o,
  output logic [USER_WIDTH-1:0] aw_user_o,
  input  logic                  aw_ready_i,

  output logic                  cmd_done_o,
  output logic                  busy_o
);

  localparam int unsigned SIZE = $clog2(DATA_BYTES);

  // Chunk arithmetic width: must hold the byte count, 4096 and 256*DATA_BYTES + off.
  localparam int unsigned CW_A = (LEN_WIDTH + 1 > SIZE + 10) ? LEN_WIDTH + 1 : SIZE + 10;
  localparam int unsigned CW   = (CW_A > 14) ? CW_A : 14;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  rem_q,      rem_d;
  logic                  aw_valid_q, aw_valid_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q,  aw_addr_d;
  logic [7:0]            aw_len_q,   aw_len_d;
  logic [ID_WIDTH-1:0]   aw_id_q,    aw_id_d;
  logic [USER_WIDTH-1:0] aw_user_q,  aw_user_d;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_rem;
  logic [CW-1:0]         off, to4k, maxb, rem_w, chunk, beats;
  logic [7:0]            burst_len;
  logic                  cmd_accept;
  logic                  aw_hs;

  assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign cmd_accept  = cmd_valid_i && cmd_ready_o;
  assign aw_hs       = aw_valid_q && aw_ready_i;

  // One shared chunk calculator: fed by the new command in IDLE, by the
  // running address/remainder in ISSUE.
  assign sel_addr = (state_q == ST_IDLE) ? cmd_addr_i : cur_addr_q;
  assign sel_rem  = (state_q == ST_IDLE) ? cmd_len_i  : rem_q;

  always_comb begin
    off   = CW'(sel_addr & ADDR_WIDTH'(DATA_BYTES - 1));
    to4k  = CW'(4096) - CW'(sel_addr[11:0]);
    maxb  = CW'(256 * DATA_BYTES) - off;
    rem_w = CW'(sel_rem);
    chunk = rem_w;
    if (to4k < chunk) chunk = to4k;
    if (maxb < chunk) chunk = maxb;
    beats     = (off + chunk + CW'(DATA_BYTES - 1)) >> SIZE;
    burst_len = 8'(beats - CW'(1));
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the
    // decision tree leaves a signal unassigned and infers a latch.
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    aw_valid_d = aw_valid_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_id_d    = aw_id_q;
    aw_user_d  = aw_user_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept && (cmd_len_i != '0)) begin
          aw_valid_d = 1'b1;
          aw_addr_d  = cmd_addr_i;
          aw_len_d   = burst_len;
          aw_id_d    = cmd_id_i;
          aw_user_d  = cmd_user_i;
          cur_addr_d = cmd_addr_i + ADDR_WIDTH'(chunk);
          rem_d      = cmd_len_i - LEN_WIDTH'(chunk);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (aw_hs) begin
          if (rem_q == '0) begin
            aw_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            aw_addr_d  = cur_addr_q;
            aw_len_d   = burst_len;
            cur_addr_d = cur_addr_q + ADDR_WIDTH'(chunk);
            rem_d      = rem_q - LEN_WIDTH'(chunk);
          end
        end
      end
      default: begin
        aw_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    // NOTE: the whole register set, including the AW payload, is reset so the
    // outputs show defined zeros right after reset rather than stale data.
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_id_q    <= '0;
      aw_user_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      aw_valid_q <= aw_valid_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_id_q    <= aw_id_d;
      aw_user_q  <= aw_user_d;
    end
  end

  // Done fires on the final handshake; suppressed while reset discards the command.
  assign cmd_done_o = (state_q == ST_ISSUE) && aw_hs && (rem_q == '0) && !rst_i;
  assign busy_o     = (state_q == ST_ISSUE);

  assign aw_valid_o  = aw_valid_q;
  assign aw_addr_o   = aw_addr_q;
  assign aw_len_o    = aw_len_q;
  assign aw_id_o     = aw_id_q;
  assign aw_user_o   = aw_user_q;
  assign aw_prot_o   = 3'b000;
  assign aw_region_o = 4'b0000;
  assign aw_size_o   = 3'(SIZE);
  assign aw_burst_o  = 2'b01;
  assign aw_lock_o   = 1'b0;
  assign aw_cache_o  = 4'b0000;
  assign aw_qos_o    = 4'b0000;

endmodule

// File: tb/tb_ext_aw_splitter.sv
// Directed plus randomized bench for ext_aw_splitter; expected bursts come
// from a queue-based model of the page/beat splitting rules.
module tb_ext_aw_splitter;

  localparam int unsigned DB = 8;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic [31:0] cmd_addr_i;
  logic [15:0] cmd_len_i;
  logic [3:0]  cmd_id_i;
  logic [5:0]  cmd_user_i;
  logic        cmd_ready_o;
  logic        aw_valid_o;
  logic [31:0] aw_addr_o;
  logic [2:0]  aw_prot_o;
  logic [3:0]  aw_region_o;
  logic [7:0]  aw_len_o;
  logic [2:0]  aw_size_o;
  logic [1:0]  aw_burst_o;
  logic        aw_lock_o;
  logic [3:0]  aw_cache_o;
  logic [3:0]  aw_qos_o;
  logic [3:0]  aw_id_o;
  logic [5:0]  aw_user_o;
  logic        aw_ready_i;
  logic        cmd_done_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  burst_t exp_q[$];
  logic [3:0] exp_id;
  logic [5:0] exp_user;

  always #5 clk_i = ~clk_i;

  ext_aw_splitter #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .USER_WIDTH(6), .DATA_BYTES(DB), .LEN_WIDTH(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .cmd_id_i(cmd_id_i), .cmd_user_i(cmd_user_i), .cmd_ready_o(cmd_ready_o),
    .aw_valid_o(aw_valid_o), .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o),
    .aw_region_o(aw_region_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
    .aw_burst_o(aw_burst_o), .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o),
    .aw_qos_o(aw_qos_o), .aw_id_o(aw_id_o), .aw_user_o(aw_user_o),
    .aw_ready_i(aw_ready_i), .cmd_done_o(cmd_done_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the command, cutting at 4 KB pages and at 256 bus words.
  task automatic build_expect(input logic [31:0] a, input int unsigned len);
    longint unsigned addr = a;
    int unsigned rem = len;
    while (rem > 0) begin
      int unsigned off  = int'(addr % DB);
      int unsigned to4k = 4096 - int'(addr % 4096);
      int unsigned maxb = 256 * DB - off;
      int unsigned c    = rem;
      burst_t b;
      if (to4k < c) c = to4k;
      if (maxb < c) c = maxb;
      b.addr = addr[31:0];
      b.len  = 8'((off + c + DB - 1) / DB - 1);
      exp_q.push_back(b);
      addr = (addr + c) & 64'hFFFF_FFFF;
      rem  = rem - c;
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] len,
                          input logic [3:0] id, input logic [5:0] user);
    @(negedge clk_i);
    check("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_len_i   = len;
    cmd_id_i    = id;
    cmd_user_i  = user;
    exp_id      = id;
    exp_user    = user;
    build_expect(a, len);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  // Consume expected bursts; first init_stall cycles hold ready low, then
  // ready is randomly withheld stall_pct percent of the time.
  task automatic drain(input int init_stall, input int stall_pct);
    int cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] h_addr;
    logic [7:0]  h_len;
    logic rdy;
    while (exp_q.size() != 0 && cyc < 4000) begin
      @(negedge clk_i);
      rdy = (cyc < init_stall) ? 1'b0 : ($urandom_range(99) >= stall_pct);
      aw_ready_i = rdy;
      cyc++;
      #1;
      check("aw_valid_in_cmd", aw_valid_o, 1);
      check("busy_in_cmd", busy_o, 1);
      check("cmd_ready_in_cmd", cmd_ready_o, 0);
      if (stalled) begin
        check("stable_addr", aw_addr_o, h_addr);
        check("stable_len", aw_len_o, h_len);
      end
      if (rdy) begin
        burst_t e = exp_q.pop_front();
        check("aw_addr", aw_addr_o, e.addr);
        check("aw_len", aw_len_o, e.len);
        check("aw_id", aw_id_o, exp_id);
        check("aw_user", aw_user_o, exp_user);
        check("cmd_done", cmd_done_o, (exp_q.size() == 0));
        stalled = 1'b0;
      end else begin
        check("cmd_done_stall", cmd_done_o, 0);
        stalled = 1'b1;
        h_addr  = aw_addr_o;
        h_len   = aw_len_o;
      end
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk_i);
    aw_ready_i = 1'b0;
    #1;
    check("aw_valid_after", aw_valid_o, 0);
    check("cmd_ready_after", cmd_ready_o, 1);
    check("busy_after", busy_o, 0);
    check("cmd_done_after", cmd_done_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    cmd_id_i = '0; cmd_user_i = '0; aw_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_aw_valid", aw_valid_o, 0);
    check("rst_cmd_done", cmd_done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_aw_addr", aw_addr_o, 0);
    check("rst_aw_len", aw_len_o, 0);
    check("rst_aw_id", aw_id_o, 0);
    check("rst_aw_user", aw_user_o, 0);
    check("const_size", aw_size_o, 3);
    check("const_burst", aw_burst_o, 1);
    check("const_misc", {aw_prot_o, aw_region_o, aw_lock_o, aw_cache_o, aw_qos_o}, 0);
    rst_i = 1'b0;
    #1;
    check("ready_after_rst", cmd_ready_o, 1);

    // Directed cases.
    send_cmd(32'h1000, 16'd64, 4'hA, 6'h15);   drain(0, 0);
    send_cmd(32'h0FF8, 16'd16, 4'h3, 6'h2A);   drain(0, 0);
    send_cmd(32'h0000, 16'd4096, 4'h5, 6'h01); drain(0, 0);
    send_cmd(32'h0003, 16'd10, 4'h7, 6'h3F);   drain(0, 0);
    send_cmd(32'h0FF8, 16'd16, 4'h9, 6'h11);   drain(5, 0);

    // Zero length: accepted, no burst, no done.
    send_cmd(32'h2000, 16'd0, 4'h1, 6'h01);
    check("zero_len_no_expect", exp_q.size(), 0);
    repeat (3) begin
      @(negedge clk_i);
      aw_ready_i = 1'b1;
      #1;
      check("zero_aw_valid", aw_valid_o, 0);
      check("zero_cmd_ready", cmd_ready_o, 1);
      check("zero_cmd_done", cmd_done_o, 0);
    end
    aw_ready_i = 1'b0;

    // Reset after the first burst of a 4096-byte command.
    send_cmd(32'h0000, 16'd4096, 4'hC, 6'h0C);
    @(negedge clk_i);
    aw_ready_i = 1'b1;
    #1;
    check("rstmid_first_valid", aw_valid_o, 1);
    check("rstmid_first_addr", aw_addr_o, 32'h0);
    check("rstmid_first_len", aw_len_o, 8'd255);
    check("rstmid_first_done", cmd_done_o, 0);
    @(negedge clk_i);
    aw_ready_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("rstmid_second_addr", aw_addr_o, 32'h800);
    check("rstmid_done_in_rst", cmd_done_o, 0);
    @(negedge clk_i);
    check("rstmid_valid_drop", aw_valid_o, 0);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_ready_in_rst", cmd_ready_o, 0);
    rst_i = 1'b0;
    aw_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("rstmid_no_aw", aw_valid_o, 0);
      check("rstmid_no_done", cmd_done_o, 0);
      check("rstmid_ready", cmd_ready_o, 1);
    end
    aw_ready_i = 1'b0;
    exp_q.delete();
    send_cmd(32'h0FF8, 16'd16, 4'h2, 6'h22);   drain(0, 0);

    // Boundary: maximum length, unaligned, wrapping past the top of memory.
    send_cmd(32'hFFFF_F001, 16'hFFFF, 4'hF, 6'h3F); drain(0, 20);

    // Randomized commands, biased toward page edges.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [15:0] l;
      a = $urandom;
      if ($urandom_range(1) == 1) a[11:0] = 12'hFFF - 12'($urandom_range(40));
      l = ($urandom_range(9) == 0) ? 16'd0 : 16'($urandom_range(9000));
      send_cmd(a, l, 4'($urandom), 6'($urandom));
      drain($urandom_range(3), 30);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_aw_splitter.md
# ext_aw_splitter

Upstream feeder for the external write-address buffer. Accepts one write-transfer command (byte address, byte count, ID, user) and emits AXI4 AW requests. Each request is an INCR burst that crosses no 4 KB boundary and has at most 256 beats. Its AW master port connects directly to the slave side of the AW buffer stage.

## Interface
Parameters:
- ID_WIDTH, 4: AW ID width.
- ADDR_WIDTH, 32: address width, ≥ 13.
- USER_WIDTH, 6: AW user width.
- DATA_BYTES, 8: data bus width in bytes; power of two, 1..128.
- LEN_WIDTH, 16: width of the byte-count field of a command.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset. One clock; reset is synchronous and active-high.
- cmd_valid_i, input, 1: command valid.
- cmd_addr_i, input, ADDR_WIDTH: start byte address; may be unaligned.
- cmd_len_i, input, LEN_WIDTH: transfer size in bytes; 0 means empty.
- cmd_id_i, input, ID_WIDTH: ID copied to every burst of the command.
- cmd_user_i, input, USER_WIDTH: user field copied to every burst.
- cmd_ready_o, output, 1: command accepted when high together with cmd_valid_i.
- aw_valid_o, output, 1: AW valid.
- aw_addr_o, output, ADDR_WIDTH: AW address.
- aw_prot_o, output, 3: constant 3'b000.
- aw_region_o, output, 4: constant 4'b0000.
- aw_len_o, output, 8: AW len, equal to beats − 1.
- aw_size_o, output, 3: constant log2(DATA_BYTES).
- aw_burst_o, output, 2: constant 2'b01 (INCR).
- aw_lock_o, output, 1: constant 0.
- aw_cache_o, output, 4: constant 4'b0000.
- aw_qos_o, output, 4: constant 4'b0000.
- aw_id_o, output, ID_WIDTH: AW ID.
- aw_user_o, output, USER_WIDTH: AW user.
- aw_ready_i, input, 1: AW ready from the AW buffer.
- cmd_done_o, output, 1: one-cycle pulse on the AW handshake of the last burst of a command.
- busy_o, output, 1: high when the FSM is in ISSUE.

## Operation
- FSM has two states: IDLE and ISSUE.
- cmd_ready_o = (state == IDLE) && !rst_i.
- Registered state:
  - cur_addr: ADDR_WIDTH bits.
  - rem: LEN_WIDTH bits, bytes still to be issued.
  - id and user.
  - The AW output register set.
- Per-burst chunk computation, using address a and remaining byte count r:
  - off = a mod DATA_BYTES.
  - to4k = 4096 − (a mod 4096), in the range 1..4096.
  - maxb = 256·DATA_BYTES − off.
  - chunk = min(r, to4k, maxb).
  - beats = ceil((off + chunk) / DATA_BYTES), in the range 1..256.
  - aw_len = beats − 1.
- Internal arithmetic must be wide enough that nothing truncates. Use 13 bits for to4k/chunk, and wider as DATA_BYTES requires.
- Command accept in IDLE (cmd_valid_i && cmd_ready_o):
  - If cmd_len_i == 0: accept, emit no AW, stay in IDLE, and do not pulse cmd_done_o.
  - Otherwise:
    - Compute the first chunk from cmd_addr_i and cmd_len_i.
    - Register aw_addr_o = cmd_addr_i; the first burst keeps any unaligned offset.
    - Register aw_len_o, aw_id_o and aw_user_o.
    - Set cur_addr = cmd_addr_i + chunk and rem = cmd_len_i − chunk.
    - Go to ISSUE.
- In ISSUE, on an AW handshake (aw_valid_o && aw_ready_i):
  - If rem == 0: pulse cmd_done_o in that same cycle, drop aw_valid_o at the next edge, and go to IDLE.
  - Else: register the next burst from cur_addr/rem, advance cur_addr and rem, and stay in ISSUE with aw_valid_o high. Bursts go back-to-back, one per cycle.
- Bursts after the first start at an aligned address, because each chunk ends either at the end of a bus word or at the end of the command.
- Address wrap past 2^ADDR_WIDTH is not detected; it wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values:
  - aw_valid_o = 0, cmd_done_o = 0, busy_o = 0.
  - aw_addr_o, aw_len_o, aw_id_o, aw_user_o = 0.
  - Constant fields hold their constant values.
  - cmd_ready_o = 0 while rst_i is high, and 1 in the first cycle after rst_i deasserts.
- Latency: command accepted at edge T → aw_valid_o high in cycle T+1.
- AXI stability: while aw_valid_o && !aw_ready_i, every AW field and aw_valid_o holds constant. aw_valid_o never depends combinationally on aw_ready_i.
- cmd_ready_o is low throughout ISSUE. It rises in the cycle after the last handshake, so the minimum command-to-command spacing is nbursts + 1 cycles.
- Assertion of rst_i at any edge, including mid-command:
  - Return to IDLE at that edge; aw_valid_o = 0 in the next cycle.
  - The remainder of the command is discarded.
  - No cmd_done_o pulse.

## Test plan
- Aligned single burst: DATA_BYTES=8, addr 0x1000, len 64 → one AW: addr 0x1000, len 7, id/user echoed; cmd_done_o pulses on its handshake.
- 4 KB crossing: addr 0x0FF8, len 16 → AW 0x0FF8 len 0, then AW 0x1000 len 0 on consecutive cycles while aw_ready_i is held at 1.
- 256-beat cap: addr 0x0, len 4096 → AW 0x000 len 255, then AW 0x800 len 255.
- Unaligned short transfer: addr 0x3, len 10 → AW 0x3 len 1 (ceil(13/8) = 2 beats).
- Backpressure and zero length:
  - aw_ready_i low for 5 cycles during the 4 KB-crossing case → all AW fields stable and aw_valid_o held throughout.
  - Then a command with len 0 → accepted, no AW, cmd_ready_o stays 1.
- Reset mid-command: assert rst_i one cycle after the first AW of the 4096-byte case → aw_valid_o 0 in the next cycle, no second AW, no cmd_done_o; after deassertion a new command splits correctly.
